// File: rtl/output_collector.sv
// output_collector: deskews per-column systolic result strobes through one small FIFO per
// column and emits complete rows on a valid/ready stream. It tracks the row index within a
// tile, pulses tile_done after the last row is handed off, and flags overflow when a strobe
// hits a full column FIFO.
// Optional build macro OUTPUT_COLLECTOR_RELU_EN: clamps negative elements to zero when a row
// is loaded into the output register.
module output_collector #(
  parameter int unsigned COLS   = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ROWS   = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [COLS-1:0]                read_out,
  input  logic [COLS-1:0][DATA_W-1:0]    o_data,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic [COLS-1:0][DATA_W-1:0]    m_data,
  output logic [$clog2(ROWS)-1:0]        m_row,
  output logic                           m_last,
  output logic                           tile_done,
  output logic                           overflow
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned RowW = $clog2(ROWS);

  logic [DATA_W-1:0]               mem_q [COLS][DEPTH];
  logic [COLS-1:0][PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [COLS-1:0][PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [COLS-1:0][CntW-1:0]       count_q, count_d;
  logic [COLS-1:0][DATA_W-1:0]     m_data_q, m_data_d;
  logic [COLS-1:0][DATA_W-1:0]     row_load;
  logic [RowW-1:0]                 m_row_q, m_row_d;
  logic                            m_valid_q, m_valid_d;
  logic                            tile_done_q, tile_done_d;
  logic                            overflow_q, overflow_d;
  logic [COLS-1:0]                 wr_acc;
  logic                            all_avail;
  logic                            pop;
  logic                            hs;
  logic                            last_row;

  // Pop/accept decisions, all based on registered counts (no write-to-read bypass).
  always_comb begin
    all_avail = 1'b1;
    for (int c = 0; c < COLS; c++) begin
      if (count_q[c] == '0) all_avail = 1'b0;
    end
    pop      = all_avail && (!m_valid_q || m_ready);
    hs       = m_valid_q && m_ready;
    last_row = (m_row_q == RowW'(ROWS - 1));
    for (int c = 0; c < COLS; c++) begin
      // A full FIFO still accepts when a pop frees the head slot in the same cycle.
      wr_acc[c] = read_out[c] && ((count_q[c] != CntW'(DEPTH)) || pop);
    end
  end

  // Next-state for FIFO pointers, counts, output register and status flags.
  always_comb begin
    for (int c = 0; c < COLS; c++) begin
      wr_ptr_d[c] = wr_ptr_q[c] + PtrW'(wr_acc[c]);
      rd_ptr_d[c] = rd_ptr_q[c] + PtrW'(pop);
      count_d[c]  = count_q[c] + CntW'(wr_acc[c]) - CntW'(pop);
`ifdef OUTPUT_COLLECTOR_RELU_EN
      row_load[c] = mem_q[c][rd_ptr_q[c]][DATA_W-1] ? '0 : mem_q[c][rd_ptr_q[c]];
`else
      row_load[c] = mem_q[c][rd_ptr_q[c]];
`endif
    end
    m_data_d  = pop ? row_load : m_data_q;
    m_valid_d = pop ? 1'b1 : (hs ? 1'b0 : m_valid_q);
    m_row_d   = m_row_q;
    if (hs) m_row_d = last_row ? '0 : m_row_q + RowW'(1);
    tile_done_d = hs && last_row;
    overflow_d  = overflow_q || ((read_out & ~wr_acc) != '0);
  end

  // State register; start clears exactly like reset and wins over any same-cycle activity.
  always_ff @(posedge clk) begin
    if (!rst || start) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      m_data_q    <= '0;
      m_valid_q   <= 1'b0;
      m_row_q     <= '0;
      tile_done_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      m_data_q    <= m_data_d;
      m_valid_q   <= m_valid_d;
      m_row_q     <= m_row_d;
      tile_done_q <= tile_done_d;
      overflow_q  <= overflow_d;
    end
  end

  // FIFO storage; contents need no reset because pointers and counts gate every read.
  always_ff @(posedge clk) begin
    for (int c = 0; c < COLS; c++) begin
      if (rst && !start && wr_acc[c]) mem_q[c][wr_ptr_q[c]] <= o_data[c];
    end
  end

  // Output drive.
  always_comb begin
    m_valid   = m_valid_q;
    m_data    = m_data_q;
    m_row     = m_row_q;
    m_last    = m_valid_q && last_row;
    tile_done = tile_done_q;
    overflow  = overflow_q;
  end

endmodule

// File: tb/tb_output_collector.sv
// Directed bench for output_collector: table of per-cycle vectors for the skewed row and a
// full tile, plus hand-written sequences for backpressure/overflow, full-with-pop streaming,
// the optional clamp and mid-operation reset.
module tb_output_collector;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [3:0]        read_out;
  logic [3:0][31:0]  o_data;
  logic              m_valid;
  logic              m_ready;
  logic [3:0][31:0]  m_data;
  logic [1:0]        m_row;
  logic              m_last;
  logic              tile_done;
  logic              overflow;

  int n_cmp = 0;
  int n_err = 0;

  output_collector #(
    .COLS(4), .DATA_W(32), .DEPTH(4), .ROWS(4)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .read_out(read_out), .o_data(o_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_row(m_row),
    .m_last(m_last), .tile_done(tile_done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             start;
    logic [3:0]       ro;
    logic [3:0][31:0] d;
    logic             rdy;
    logic             e_valid;
    logic [3:0][31:0] e_data;
    logic [1:0]       e_row;
    logic             e_last;
    logic             e_done;
    logic             e_ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0][31:0] rowv(input int base);
    logic [3:0][31:0] r;
    for (int c = 0; c < 4; c++) r[c] = 32'(base + c);
    return r;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   got;
    logic [3:0][31:0] exp_relu;

    // Build table: skewed single row, then start, then a full 4-row tile.
    for (int t = 0; t < 6; t++) begin
      v = '{default: '0};
      v.rdy = 1'b1;
      if (t < 4) begin
        v.ro[t] = 1'b1;
        v.d[t]  = 32'(100 + t);
      end
      v.e_valid = (t == 4);
      v.e_data  = (t >= 4) ? rowv(100) : '0;
      v.e_row   = (t == 5) ? 2'd1 : 2'd0;
      vecs.push_back(v);
    end
    v = '{default: '0};
    v.start = 1'b1;
    v.rdy   = 1'b1;
    vecs.push_back(v);
    for (int t = 0; t < 10; t++) begin
      v = '{default: '0};
      v.rdy = 1'b1;
      for (int c = 0; c < 4; c++) begin
        if (t - c >= 0 && t - c < 4) begin
          v.ro[c] = 1'b1;
          v.d[c]  = 32'(16 * (t - c) + c);
        end
      end
      if (t >= 4 && t <= 7) begin
        v.e_valid = 1'b1;
        v.e_data  = rowv(16 * (t - 4));
        v.e_row   = 2'(t - 4);
        v.e_last  = (t == 7);
      end else if (t >= 8) begin
        v.e_data = rowv(48);
        v.e_done = (t == 8);
      end
      vecs.push_back(v);
    end

    // Reset with strobes active.
    rst      = 1'b0;
    start    = 1'b0;
    read_out = 4'hF;
    o_data   = rowv(900);
    m_ready  = 1'b0;
    step();
    step();
    rst      = 1'b1;
    read_out = 4'h0;
    chk("rst_valid", m_valid, 1'b0);
    chk("rst_data", m_data, '0);
    chk("rst_row", m_row, 2'd0);
    chk("rst_last", m_last, 1'b0);
    chk("rst_done", tile_done, 1'b0);
    chk("rst_ovf", overflow, 1'b0);

    // Table-driven vectors.
    foreach (vecs[i]) begin
      start    = vecs[i].start;
      read_out = vecs[i].ro;
      o_data   = vecs[i].d;
      m_ready  = vecs[i].rdy;
      step();
      chk($sformatf("v%0d_valid", i), m_valid, vecs[i].e_valid);
      chk($sformatf("v%0d_data", i), m_data, vecs[i].e_data);
      chk($sformatf("v%0d_row", i), m_row, vecs[i].e_row);
      chk($sformatf("v%0d_last", i), m_last, vecs[i].e_last);
      chk($sformatf("v%0d_done", i), tile_done, vecs[i].e_done);
      chk($sformatf("v%0d_ovf", i), overflow, vecs[i].e_ovf);
    end
    read_out = 4'h0;
    start    = 1'b0;

    // Backpressure / overflow on column 0.
    start = 1'b1;
    step();
    start   = 1'b0;
    m_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      read_out  = 4'h1;
      o_data[0] = 32'(200 + k);
      step();
      chk($sformatf("bp_ovf%0d", k), overflow, (k >= 4));
    end
    read_out = 4'h0;
    step();
    for (int k = 0; k < 4; k++) begin
      read_out = 4'hE;
      o_data   = rowv(300 + 4 * k);
      o_data[0] = 32'd0;
      step();
      if (k >= 1) begin
        chk($sformatf("bp_hold_valid%0d", k), m_valid, 1'b1);
        chk($sformatf("bp_hold_c0_%0d", k), m_data[0], 32'd200);
        chk($sformatf("bp_hold_c1_%0d", k), m_data[1], 32'd301);
      end
    end
    read_out = 4'h0;
    m_ready  = 1'b1;
    got      = 0;
    for (int i = 0; i < 12 && got < 4; i++) begin
      if (m_valid) begin
        chk($sformatf("bp_drain_c0_%0d", got), m_data[0], 32'(200 + got));
        chk($sformatf("bp_drain_c1_%0d", got), m_data[1], 32'(301 + 4 * got));
        got++;
      end
      step();
    end
    chk("bp_drain_count", got, 4);
    chk("bp_ovf_sticky", overflow, 1'b1);
    for (int k = 0; k < 2; k++) begin
      read_out  = 4'h1;
      o_data[0] = 32'(250 + k);
      step();
    end
    read_out = 4'h0;
    start    = 1'b1;
    step();
    start = 1'b0;
    chk("start_ovf", overflow, 1'b0);
    chk("start_valid", m_valid, 1'b0);
    read_out = 4'hF;
    o_data   = rowv(400);
    step();
    read_out = 4'h0;
    chk("lat_not_yet", m_valid, 1'b0);
    step();
    chk("lat_valid", m_valid, 1'b1);
    chk("start_empty_data", m_data, rowv(400));
    step();
    chk("lat_drop", m_valid, 1'b0);

    // Full FIFOs with simultaneous pop: one row per cycle, no overflow.
    start = 1'b1;
    step();
    start   = 1'b0;
    m_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      read_out = 4'hF;
      o_data   = rowv(1000 + 4 * k);
      step();
    end
    chk("fp_fill_data", m_data, rowv(1000));
    chk("fp_fill_ovf", overflow, 1'b0);
    m_ready = 1'b1;
    for (int j = 0; j < 6; j++) begin
      read_out = 4'hF;
      o_data   = rowv(1000 + 4 * (5 + j));
      step();
      chk($sformatf("fp_stream_valid%0d", j), m_valid, 1'b1);
      chk($sformatf("fp_stream_data%0d", j), m_data, rowv(1000 + 4 * (1 + j)));
      chk($sformatf("fp_stream_ovf%0d", j), overflow, 1'b0);
    end
    read_out = 4'h0;
    for (int d = 0; d < 4; d++) begin
      step();
      chk($sformatf("fp_drain_valid%0d", d), m_valid, 1'b1);
      chk($sformatf("fp_drain_data%0d", d), m_data, rowv(1000 + 4 * (7 + d)));
    end
    step();
    chk("fp_end_valid", m_valid, 1'b0);

    // Signed clamp check: col3..col0 = {-1, 7, 0, -5}.
    start = 1'b1;
    step();
    start    = 1'b0;
    read_out = 4'hF;
    o_data[0] = 32'hFFFF_FFFB;
    o_data[1] = 32'd0;
    o_data[2] = 32'd7;
    o_data[3] = 32'hFFFF_FFFF;
`ifdef OUTPUT_COLLECTOR_RELU_EN
    exp_relu = {32'd0, 32'd7, 32'd0, 32'd0};
`else
    exp_relu = {32'hFFFF_FFFF, 32'd7, 32'd0, 32'hFFFF_FFFB};
`endif
    step();
    read_out = 4'h0;
    m_ready  = 1'b0;
    step();
    chk("relu_valid", m_valid, 1'b1);
    chk("relu_data", m_data, exp_relu);

    // Reset mid-operation discards buffered data.
    read_out = 4'hF;
    o_data   = rowv(700);
    step();
    read_out = 4'h0;
    rst      = 1'b0;
    step();
    rst = 1'b1;
    chk("midrst_valid", m_valid, 1'b0);
    chk("midrst_data", m_data, '0);
    m_ready = 1'b1;
    step();
    chk("midrst_empty", m_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
